// File: rtl/fc_weight_pingpong_buf.sv
// fc_weight_pingpong_buf: double-buffered per-lane weight store with diagonally skewed read-out
// Optional macro FC_WBUF_REUSE_EN adds rd_keep_i: a completed read keeps its bank FULL for reuse.
// Ports: clk/rst; write side wr_en_i, wr_addr_i, wr_data_i, wr_commit_i, wr_ready_o;
// read side rd_start_i, rd_len_i, [rd_keep_i], rd_avail_o, rd_busy_o, rd_done_o, weight_o, weight_vld_o.
module fc_weight_pingpong_buf #(
  parameter int LANES = 120,
  parameter int DEPTH = 84,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic [LANES*DATA_W-1:0]   wr_data_i,
  input  logic                      wr_commit_i,
  output logic                      wr_ready_o,
  input  logic                      rd_start_i,
  input  logic [LEN_W-1:0]          rd_len_i,
`ifdef FC_WBUF_REUSE_EN
  input  logic                      rd_keep_i,
`endif
  output logic                      rd_avail_o,
  output logic                      rd_busy_o,
  output logic                      rd_done_o,
  output logic [LANES*DATA_W-1:0]   weight_o,
  output logic [LANES-1:0]          weight_vld_o
);
  typedef enum logic [1:0] {EMPTY, FULL, READING} bank_t;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} seq_t;
  bank_t bank [2];
  seq_t state;
  logic load_sel, read_sel, rel;
  logic [LEN_W-1:0] len;
  logic [ADDR_W-1:0] addr_d [LANES];
  logic [LANES-1:0] en_d;
  logic wr_ok, commit_ok, start_ok, finish;
  assign wr_ready_o = bank[load_sel] == EMPTY;
  assign rd_busy_o = state != IDLE;
  assign rd_avail_o = state == IDLE && bank[read_sel] == FULL;
  assign wr_ok = wr_en_i && wr_ready_o && ({1'b0, wr_addr_i} < (ADDR_W + 1)'(DEPTH));
  assign commit_ok = wr_commit_i && wr_ready_o;
  assign start_ok = rd_start_i && rd_avail_o && rd_len_i != '0 && rd_len_i <= LEN_W'(DEPTH);
  // last lane shows its final word: output valid while its address chain has already drained
  assign finish = state == FLUSH && weight_vld_o[LANES-1] && !en_d[LANES-1] && !rd_done_o;
`ifdef FC_WBUF_REUSE_EN
  logic keep;
  assign rel = !keep;
  always_ff @(posedge clk)
    if (rst) keep <= 1'b0;
    else if (start_ok) keep <= rd_keep_i;
`else
  assign rel = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      bank[0] <= EMPTY;
      bank[1] <= EMPTY;
      load_sel <= 1'b0;
      read_sel <= 1'b0;
      state <= IDLE;
      len <= '0;
      en_d <= '0;
      rd_done_o <= 1'b0;
      weight_vld_o <= '0;
      for (int i = 0; i < LANES; i++) addr_d[i] <= '0;
    end else begin
      rd_done_o <= finish;
      weight_vld_o <= en_d;
      en_d[LANES-1:1] <= en_d[LANES-2:0];
      for (int i = 1; i < LANES; i++) addr_d[i] <= addr_d[i-1];
      if (commit_ok) begin
        bank[load_sel] <= FULL;
        load_sel <= !load_sel;
      end
      case (state)
        IDLE: if (start_ok) begin
          len <= rd_len_i;
          bank[read_sel] <= READING;
          en_d[0] <= 1'b1;
          addr_d[0] <= '0;
          state <= STREAM;
        end
        STREAM: if (LEN_W'(addr_d[0]) + LEN_W'(1) == len) begin
          en_d[0] <= 1'b0;
          state <= FLUSH;
        end else addr_d[0] <= addr_d[0] + ADDR_W'(1);
        FLUSH: if (rd_done_o) begin
          bank[read_sel] <= rel ? EMPTY : FULL;
          read_sel <= read_sel ^ rel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [DATA_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (wr_ok) mem[load_sel][wr_addr_i] <= wr_data_i[g*DATA_W +: DATA_W];
      rd_q <= mem[read_sel][addr_d[g]];
    end
    assign weight_o[g*DATA_W +: DATA_W] = weight_vld_o[g] ? rd_q : '0;
  end
endmodule

// File: tb/tb_fc_weight_pingpong_buf.sv
// tb_fc_weight_pingpong_buf: directed self-checking bench for fc_weight_pingpong_buf (LANES=4, DEPTH=8)
module tb_fc_weight_pingpong_buf;
  localparam int LANES = 4, DEPTH = 8, DATA_W = 8, ADDR_W = 3, LEN_W = 4;
  logic clk = 0, rst = 1;
  logic wr_en = 0, wr_commit = 0, rd_start = 0, rd_keep = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [LANES*DATA_W-1:0] wr_data = '0;
  logic [LEN_W-1:0] rd_len = '0;
  logic wr_ready, rd_avail, rd_busy, rd_done;
  logic [LANES*DATA_W-1:0] weight;
  logic [LANES-1:0] weight_vld;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fc_weight_pingpong_buf #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_commit_i(wr_commit),
    .wr_ready_o(wr_ready), .rd_start_i(rd_start), .rd_len_i(rd_len),
`ifdef FC_WBUF_REUSE_EN
    .rd_keep_i(rd_keep),
`endif
    .rd_avail_o(rd_avail), .rd_busy_o(rd_busy), .rd_done_o(rd_done),
    .weight_o(weight), .weight_vld_o(weight_vld)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [LANES*DATA_W-1:0] exp_w(input int base, input int c, input int len);
    logic [LANES*DATA_W-1:0] w = '0;
    for (int i = 0; i < LANES; i++)
      if (c - 2 - i >= 0 && c - 2 - i < len) w[i*DATA_W +: DATA_W] = 8'(base + 16 * i + c - 2 - i);
    return w;
  endfunction
  function automatic logic [LANES-1:0] exp_v(input int c, input int len);
    logic [LANES-1:0] v = '0;
    for (int i = 0; i < LANES; i++) v[i] = c - 2 - i >= 0 && c - 2 - i < len;
    return v;
  endfunction
  task automatic write_rows(input int base);
    for (int k = 0; k < DEPTH; k++) begin
      wr_en = 1;
      wr_addr = ADDR_W'(k);
      for (int i = 0; i < LANES; i++) wr_data[i*DATA_W +: DATA_W] = 8'(base + 16 * i + k);
      step();
    end
    wr_en = 0;
  endtask
  task automatic commit();
    wr_commit = 1;
    step();
    wr_commit = 0;
  endtask
  task automatic run_stream(input int base, input int len, input bit chk_rdy);
    rd_start = 1;
    rd_len = LEN_W'(len);
    step();
    rd_start = 0;
    for (int c = 1; c <= len + 6; c++) begin
      chk($sformatf("w_c%0d", c), weight, exp_w(base, c, len));
      chk($sformatf("vld_c%0d", c), weight_vld, exp_v(c, len));
      chk($sformatf("done_c%0d", c), rd_done, c == len + LANES + 1);
      if (chk_rdy) chk($sformatf("rdy_c%0d", c), wr_ready, 1);
      step();
    end
    chk("busy_end", rd_busy, 0);
  endtask
  initial begin
    int seen_done;
    step();
    step();
    rst = 0;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_avail", rd_avail, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_done", rd_done, 0);
    chk("rst_weight", weight, 0);
    chk("rst_vld", weight_vld, 0);
    write_rows(0);
    commit();
    chk("t1_avail", rd_avail, 1);
    chk("t1_ready", wr_ready, 1);
    run_stream(0, 8, 1);
    write_rows(8'h80);
    commit();
    fork
      run_stream(8'h80, 8, 0);
      begin
        write_rows(8'h40);
        commit();
        chk("t2_ready_lo", wr_ready, 0);
        repeat (4) step();
        chk("t2_ready_done", wr_ready, 0);
        step();
        chk("t2_ready_back", wr_ready, 1);
      end
    join
    chk("t2_avail", rd_avail, 1);
    run_stream(8'h40, 8, 0);
    rd_start = 1;
    rd_len = 4;
    step();
    rd_start = 0;
    chk("t3_nofull_busy", rd_busy, 0);
    step();
    chk("t3_nofull_vld", weight_vld, 0);
    write_rows(8);
    commit();
    rd_start = 1;
    rd_len = 0;
    step();
    chk("t3_len0_busy", rd_busy, 0);
    rd_len = 9;
    step();
    rd_start = 0;
    chk("t3_len9_busy", rd_busy, 0);
    chk("t3_len9_vld", weight_vld, 0);
    chk("t3_avail", rd_avail, 1);
    write_rows(8'h60);
    commit();
    chk("t3_both_full", wr_ready, 0);
    wr_en = 1;
    wr_addr = 0;
    wr_data = '1;
    wr_commit = 1;
    step();
    wr_en = 0;
    wr_commit = 0;
    run_stream(8, 8, 0);
    chk("t3_ready_after", wr_ready, 1);
    fork
      run_stream(8'h60, 3, 0);
      begin
        write_rows(8'h90);
        commit();
        chk("t4_avail", rd_avail, 1);
        chk("t4_ready", wr_ready, 1);
      end
    join
    run_stream(8'h90, 8, 1);
    write_rows(8'h50);
    commit();
    rd_start = 1;
    rd_len = 8;
    step();
    rd_start = 0;
    repeat (5) step();
    chk("t5_vld_pre", weight_vld, 4'hF);
    rst = 1;
    step();
    rst = 0;
    chk("t5_vld", weight_vld, 0);
    chk("t5_weight", weight, 0);
    chk("t5_ready", wr_ready, 1);
    chk("t5_busy", rd_busy, 0);
    chk("t5_avail", rd_avail, 0);
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      seen_done += int'(rd_done);
      step();
    end
    chk("t5_no_done", seen_done, 0);
`ifdef FC_WBUF_REUSE_EN
    write_rows(8'h30);
    commit();
    rd_keep = 1;
    run_stream(8'h30, 3, 1);
    chk("t6_kept_avail", rd_avail, 1);
    rd_keep = 0;
    run_stream(8'h30, 3, 1);
    chk("t6_released", rd_avail, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
